// File: rtl/histogram_builder.sv
`default_nettype none
// ============================================================================
//  Module   : histogram_builder
//  Purpose  : Builds a 256-bin luminance histogram in an external RAM: clear,
//             then pipelined read-modify-write per pixel with write forwarding.
//  Revision : 1.0  initial release
// ============================================================================
module histogram_builder #(
    parameter int WORD_SIZE  = 20,
    parameter int NUM_PIXELS = 800*480
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
    input  logic [7:0]           iPixel,
    input  logic                 iPixelValid,
    output logic                 oReady,
    output logic [7:0]           oAddrRdHist,
    input  logic [WORD_SIZE-1:0] iQHist,
    output logic [7:0]           oAddrWrHist,
    output logic [WORD_SIZE-1:0] oDataWrHist,
    output logic                 oWE,
    output logic [19:0]          oPixelCount,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam logic [19:0]          c_NUM_PIXELS = 20'(NUM_PIXELS);
    localparam logic [WORD_SIZE-1:0] c_MAX        = {WORD_SIZE{1'b1}};
    localparam logic [WORD_SIZE-1:0] c_ONE        = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t r_state, w_state_next;

    logic [1:0]           r_drain_cnt, w_drain_next;
    logic [19:0]          r_pixel_count;
    logic [7:0]           r_rd_addr;
    logic                 r_s1_valid;
    logic                 r_s2_valid;
    logic [7:0]           r_s2_bin;
    logic                 r_we, w_we_next;
    logic [7:0]           r_wr_addr, w_wa_next;
    logic [WORD_SIZE-1:0] r_wr_data, w_wd_next;
    logic                 r_w2_we;
    logic [7:0]           r_w2_addr;
    logic [WORD_SIZE-1:0] r_w2_data;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_last_accept;
    logic [WORD_SIZE-1:0] w_base;
    logic [WORD_SIZE-1:0] w_sum;

    // A start pulse aborts the frame, so a pixel offered alongside it is dropped.
    assign w_ready       = (r_state == ST_ACCUM) && (r_pixel_count < c_NUM_PIXELS);
    assign w_accept      = iPixelValid && w_ready && !iStart;
    assign w_last_accept = w_accept && (r_pixel_count == c_NUM_PIXELS - 20'd1);

    always_comb begin
        w_state_next = r_state;
        w_drain_next = r_drain_cnt;
        case (r_state)
            ST_IDLE:  w_state_next = ST_IDLE;
            ST_CLEAR: if (r_wr_addr == 8'hFF) w_state_next = ST_ACCUM;
            ST_ACCUM: begin
                if (w_last_accept) begin
                    w_state_next = ST_DRAIN;
                    w_drain_next = 2'd0;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == 2'd2) w_state_next = ST_DONE;
                else                     w_drain_next = r_drain_cnt + 2'd1;
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
        if (iStart) w_state_next = ST_CLEAR;
    end

    // The RAM returns old data when read and written on the same edge, so the
    // write committing now (W1) and the one committed last cycle (W2) override it.
    always_comb begin
        w_base = iQHist;
        if (r_w2_we && (r_w2_addr == r_s2_bin)) w_base = r_w2_data;
        if (r_we && (r_wr_addr == r_s2_bin))    w_base = r_wr_data;
    end

    assign w_sum = (w_base == c_MAX) ? c_MAX : (w_base + c_ONE);

    always_comb begin
        w_we_next = r_s2_valid;
        w_wa_next = r_s2_bin;
        w_wd_next = w_sum;
        if (w_state_next == ST_CLEAR) begin
            w_we_next = 1'b1;
            w_wd_next = '0;
            w_wa_next = (r_state == ST_CLEAR && !iStart) ? (r_wr_addr + 8'd1) : 8'd0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state       <= ST_IDLE;
            r_drain_cnt   <= 2'd0;
            r_pixel_count <= 20'd0;
            r_rd_addr     <= 8'd0;
            r_s1_valid    <= 1'b0;
            r_s2_valid    <= 1'b0;
            r_s2_bin      <= 8'd0;
            r_we          <= 1'b0;
            r_wr_addr     <= 8'd0;
            r_wr_data     <= '0;
            r_w2_we       <= 1'b0;
            r_w2_addr     <= 8'd0;
            r_w2_data     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_next;
            r_s1_valid  <= w_accept;
            r_s2_valid  <= r_s1_valid && !iStart;
            r_s2_bin    <= r_rd_addr;
            if (w_accept) r_rd_addr <= iPixel;
            r_we        <= w_we_next;
            r_wr_addr   <= w_wa_next;
            r_wr_data   <= w_wd_next;
            r_w2_we     <= r_we;
            r_w2_addr   <= r_wr_addr;
            r_w2_data   <= r_wr_data;
            // Count survives an abort and is only zeroed once the new clear completes.
            if (r_state == ST_CLEAR && w_state_next == ST_ACCUM)
                r_pixel_count <= 20'd0;
            else if (w_accept)
                r_pixel_count <= r_pixel_count + 20'd1;
        end
    end

    assign oReady      = w_ready;
    assign oAddrRdHist = r_rd_addr;
    assign oAddrWrHist = r_wr_addr;
    assign oDataWrHist = r_wr_data;
    assign oWE         = r_we;
    assign oPixelCount = r_pixel_count;
    assign oBusy       = (r_state == ST_CLEAR) || (r_state == ST_ACCUM) || (r_state == ST_DRAIN);
    assign oDone       = (r_state == ST_DONE);

endmodule
`default_nettype wire
